// File: rtl/mips_pkg.sv
// Shared definitions for the data-side memory system: I/O page offsets, timer
// control bit positions and the address-region decode.
package mips_pkg;

  localparam logic [7:0] IO_SW     = 8'h00;
  localparam logic [7:0] IO_LED    = 8'h04;
  localparam logic [7:0] IO_TCTRL  = 8'h08;
  localparam logic [7:0] IO_TCOUNT = 8'h0C;
  localparam logic [7:0] IO_TCMP   = 8'h10;
  localparam logic [7:0] IO_TSTAT  = 8'h14;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;
  localparam int TCTRL_IRQ  = 2;
  localparam int TCTRL_BITS = 3;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_IO   = 2'd1,
    REG_NONE = 2'd2
  } addr_region_e;

  // RAM takes priority should a parameterisation ever make the two regions overlap.
  function automatic addr_region_e decode_region(input logic [31:0] a,
                                                 input logic [31:0] ram_bytes,
                                                 input logic [23:0] io_page);
    addr_region_e r;
    if (a < ram_bytes) r = REG_RAM;
    else if (a[31:8] == io_page) r = REG_IO;
    else r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_io_mmio_timer.sv
// Compare/interrupt timer living in the I/O page: TCTRL, TCOUNT, TCMP, TSTAT
// registers, the match detector, the level interrupt and the register read mux.
module mmio_timer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [5:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  logic [TCTRL_BITS-1:0] r_ctrl;
  logic [31:0]           r_count;
  logic [31:0]           r_cmp;
  logic                  r_flag;

  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_count;
  logic w_wr_cmp;
  logic w_wr_stat;
  logic w_match;

  assign w_wr       = i_sel & i_we;
  assign w_wr_ctrl  = w_wr & (i_off == IO_TCTRL[7:2]);
  assign w_wr_count = w_wr & (i_off == IO_TCOUNT[7:2]);
  assign w_wr_cmp   = w_wr & (i_off == IO_TCMP[7:2]);
  assign w_wr_stat  = w_wr & (i_off == IO_TSTAT[7:2]);

  // Compare on the pre-edge count so a match is seen even when it reloads/wraps.
  assign w_match = r_ctrl[TCTRL_EN] & (r_count == r_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_count <= '0;
      r_cmp   <= 32'hFFFF_FFFF;
      r_flag  <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= i_wdata[TCTRL_BITS-1:0];
      if (w_wr_cmp)  r_cmp  <= i_wdata;

      if (w_wr_count)                          r_count <= i_wdata;
      else if (w_match && r_ctrl[TCTRL_AUTO])  r_count <= '0;
      else if (r_ctrl[TCTRL_EN])               r_count <= r_count + 32'd1;

      // A new match beats a simultaneous write-1-to-clear.
      if (w_match)                      r_flag <= 1'b1;
      else if (w_wr_stat && i_wdata[0]) r_flag <= 1'b0;
    end
  end

  assign o_irq = r_flag & r_ctrl[TCTRL_IRQ];

  always_comb begin
    o_rdata = '0;
    case (i_off)
      IO_TCTRL[7:2]:  o_rdata = {{(32-TCTRL_BITS){1'b0}}, r_ctrl};
      IO_TCOUNT[7:2]: o_rdata = r_count;
      IO_TCMP[7:2]:   o_rdata = r_cmp;
      IO_TSTAT[7:2]:  o_rdata = {31'b0, r_flag};
      default:        o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_io.sv
// Data-side memory system for the single-cycle core: word RAM plus an I/O page
// with switches, LEDs and the timer. Loads are combinational, stores land at the edge.
module data_mem_io
  import mips_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00,
  parameter int          SW_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_we,
  input  logic [31:0]         addr,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [SW_WIDTH-1:0] led_out,
  output logic                timer_irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]         r_ram [0:RAM_WORDS-1];
  logic [SW_WIDTH-1:0] r_led;
  logic [SW_WIDTH-1:0] r_sw_meta;
  logic [SW_WIDTH-1:0] r_sw_sync;

  addr_region_e  w_region;
  logic [AW-1:0] w_ram_idx;
  logic [5:0]    w_io_off;
  logic          w_io_sel;
  logic [31:0]   w_tmr_rdata;
  logic [31:0]   w_read_data;

  assign w_region  = decode_region(addr, RAM_BYTES, IO_BASE[31:8]);
  assign w_ram_idx = addr[AW+1:2];
  assign w_io_off  = addr[7:2];
  assign w_io_sel  = (w_region == REG_IO);

  // RAM is not reset, but a store coinciding with reset must still be dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_we && (w_region == REG_RAM))
      r_ram[w_ram_idx] <= write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if (mem_we && w_io_sel && (w_io_off == IO_LED[7:2]))
        r_led <= write_data[SW_WIDTH-1:0];
    end
  end

  mmio_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_sel   (w_io_sel),
    .i_we    (mem_we),
    .i_off   (w_io_off),
    .i_wdata (write_data),
    .o_rdata (w_tmr_rdata),
    .o_irq   (timer_irq)
  );

  always_comb begin
    w_read_data = '0;
    case (w_region)
      REG_RAM: w_read_data = r_ram[w_ram_idx];
      REG_IO: begin
        case (w_io_off)
          IO_SW[7:2]:  w_read_data = 32'(r_sw_sync);
          IO_LED[7:2]: w_read_data = 32'(r_led);
          default:     w_read_data = w_tmr_rdata;
        endcase
      end
      default: w_read_data = '0;
    endcase
  end

  assign read_data = w_read_data;
  assign led_out   = r_led;

endmodule
